// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared encodings for the output port bank
package out_port_pkg;

   typedef enum logic [1:0] {
      MODE_WRITE  = 2'b00,
      MODE_SET    = 2'b01,
      MODE_CLEAR  = 2'b10,
      MODE_TOGGLE = 2'b11
   } write_mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_PULSE = 1'b1
   } pulse_state_t;

   localparam int RD_WIDTH = 32;

   // A single channel still needs a one-bit select.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/out_port_channel.sv
// rtl/out_port_channel.sv - one output channel: value register, mode arithmetic, pulse FSM (OUT_PORT_BANK_PULSE_EN)
module out_port_channel
   import out_port_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int PULSE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  write_mode_t      wr_mode,
   input  logic [WIDTH-1:0] wr_data,
`ifdef OUT_PORT_BANK_PULSE_EN
   input  logic             wr_pulse,
   output logic             busy,
`endif
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] result;

   always_comb begin
      result = wr_data;
      case (wr_mode)
         MODE_WRITE:  result = wr_data;
         MODE_SET:    result = value | wr_data;
         MODE_CLEAR:  result = value & ~wr_data;
         MODE_TOGGLE: result = value ^ wr_data;
         default:     result = wr_data;
      endcase
   end

`ifdef OUT_PORT_BANK_PULSE_EN
   localparam int CW = $clog2(PULSE_CYCLES + 1);

   pulse_state_t     state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] saved_q, saved_d;
   logic [WIDTH-1:0] value_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         saved_q <= '0;
         value   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         saved_q <= saved_d;
         value   <= value_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      saved_d = saved_q;
      value_d = value;
      if (state_q == ST_PULSE) begin
         if (cnt_q == CW'(1)) begin
            value_d = saved_q;
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
      // A write overrides both countdown and restore; a re-pulse keeps the original restore value.
      if (wr_en) begin
         value_d = result;
         if (wr_pulse) begin
            saved_d = (state_q == ST_PULSE) ? saved_q : value;
            state_d = ST_PULSE;
            cnt_d   = CW'(PULSE_CYCLES);
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end
   end

   assign busy = (state_q == ST_PULSE);
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (wr_en) begin
         value <= result;
      end
   end
`endif

endmodule

// File: rtl/out_port_bank.sv
// rtl/out_port_bank.sv - bank of register-driven output channels with read-back; pulse mode under OUT_PORT_BANK_PULSE_EN
module out_port_bank
   import out_port_pkg::*;
#(
   parameter int NUM_PORTS    = 4,
   parameter int WIDTH        = 8,
   parameter int PULSE_CYCLES = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [addr_width(NUM_PORTS)-1:0] addr,
   input  logic [31:0]                     write_data,
   input  logic [1:0]                      write_mode,
   input  logic                            write_enable,
   input  logic                            read_enable,
`ifdef OUT_PORT_BANK_PULSE_EN
   input  logic                            write_pulse,
   output logic [NUM_PORTS-1:0]            pulse_busy,
`endif
   output logic [RD_WIDTH-1:0]             read_data,
   output logic                            read_valid,
   output logic [NUM_PORTS*WIDTH-1:0]      port
);

   localparam int AW = addr_width(NUM_PORTS);

   logic [WIDTH-1:0] ch_val [NUM_PORTS];
   logic [WIDTH-1:0] rd_sel;
   logic             unused_wdata;

   assign unused_wdata = ^write_data;

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_ch
         logic ch_we;
         // The extra top bit makes addresses at or above NUM_PORTS match no channel.
         assign ch_we = write_enable && ({1'b0, addr} == (AW+1)'(g));

         out_port_channel #(
            .WIDTH        (WIDTH),
            .PULSE_CYCLES (PULSE_CYCLES)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (ch_we),
            .wr_mode  (write_mode_t'(write_mode)),
            .wr_data  (write_data[WIDTH-1:0]),
`ifdef OUT_PORT_BANK_PULSE_EN
            .wr_pulse (write_pulse),
            .busy     (pulse_busy[g]),
`endif
            .value    (ch_val[g])
         );

         assign port[g*WIDTH +: WIDTH] = ch_val[g];
      end
   endgenerate

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if ({1'b0, addr} == (AW+1)'(i)) rd_sel = ch_val[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= read_enable;
         if (read_enable) read_data <= RD_WIDTH'(rd_sel);
      end
   end

endmodule

// File: doc/out_port_bank.md
OUT_PORT_BANK -- requirements
Module: out_port_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of output channels, legal range 1..16.
REQ-002 SHALL have parameter WIDTH, default 8: bits per channel, legal range 1..32.
REQ-003 SHALL have parameter PULSE_CYCLES, default 16: pulse hold length in clk cycles, legal range 1..65535.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port addr  input  AW = max(1, clog2(NUM_PORTS))  channel select for reads and writes.
REQ-007 SHALL have port write_data  input  32  write operand; bits [31:WIDTH] ignored.
REQ-008 SHALL have port write_mode  input  2  00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE.
REQ-009 SHALL have port write_enable  input  1  write strobe, one operation per cycle.
REQ-010 SHALL have port read_enable  input  1  read strobe.
REQ-011 SHALL have port read_data  output  32  selected channel value, zero-extended.
REQ-012 SHALL have port read_valid  output  1  high for one cycle when read_data is valid.
REQ-013 SHALL have port port  output  NUM_PORTS*WIDTH  channel i on bits [i*WIDTH +: WIDTH]; driven directly from registers.

Function
REQ-014 SHALL update the addressed channel on the clk edge sampling write_enable=1; the new value is visible on port in the following cycle.
REQ-015 SHALL compute the new value per mode as WRITE = d, SET = v|d, CLEAR = v&~d, TOGGLE = v^d, where d = write_data[WIDTH-1:0] and v = current value.
REQ-016 SHALL register read_data and read_valid one cycle after read_enable=1, with read_data = the channel value before any same-cycle write.
REQ-017 SHALL ignore writes with addr >= NUM_PORTS; reads with addr >= NUM_PORTS SHALL return read_data = 0 with read_valid = 1.
REQ-018 SHALL hold read_data at its last value while read_valid = 0.
REQ-019 SHALL leave unaddressed channels unchanged.

Reset
REQ-020 SHALL clear all channel values, read_data, read_valid, every pulse counter and every pulse state to zero/IDLE on any clk edge with rst=1.
REQ-021 SHALL give rst priority over same-cycle write_enable and read_enable, and over any active pulse (a pulse aborts with no restore).

Configuration
REQ-022 SHALL compile pulse mode in only when OUT_PORT_BANK_PULSE_EN is defined.
REQ-023 With OUT_PORT_BANK_PULSE_EN, SHALL add input write_pulse (1 bit) and output pulse_busy (NUM_PORTS bits, one per channel).
REQ-024 With the macro, a write with write_pulse=1 SHALL save the pre-write value, apply the mode result, enter PULSE state, and load a counter with PULSE_CYCLES.
REQ-025 In PULSE state, SHALL decrement the counter each cycle; the written value SHALL be visible on port for exactly PULSE_CYCLES cycles, then the saved value is restored and the channel returns to IDLE.
REQ-026 pulse_busy[i] SHALL be high exactly while channel i is in PULSE.
REQ-027 A pulse write to a channel already in PULSE SHALL restart the counter, apply the new value, and keep the originally saved restore value.
REQ-028 A non-pulse write to a channel in PULSE SHALL cancel the pulse; the written value persists and the channel goes to IDLE.
REQ-029 A write landing in the restore cycle SHALL win over the restore.
REQ-030 Without the macro, SHALL have no write_pulse or pulse_busy ports and no counters, and SHALL behave exactly as REQ-014..REQ-019.

Structure
REQ-031 SHALL define the write_mode encodings, the IDLE/PULSE state encoding and the read_data width constant in shared package out_port_pkg.
REQ-032 SHALL implement per-channel value, mode arithmetic and pulse FSM/counter in sub-module out_port_channel, instantiated NUM_PORTS times via generate.

Verification
REQ-033 Reset: drive rst=1 for 2 cycles with write_enable=1 -> port = 0, read_valid = 0, pulse_busy = 0.
REQ-034 Modes on ch1: WRITE 0xA5, SET 0x0F, CLEAR 0x81, TOGGLE 0xFF -> port[15:8] reads 0xA5, 0xAF, 0x2E, 0xD1; other channels remain 0.
REQ-035 Same-cycle read and write of ch2 (old 0x33, WRITE 0x44) -> next cycle read_data = 0x33, read_valid = 1; following cycle port[23:16] = 0x44.
REQ-036 Out-of-range access with NUM_PORTS=3: write to addr 3 -> no port change; read addr 3 -> read_data = 0.
REQ-037 Pulse (macro on, PULSE_CYCLES=4): ch0 = 0x01, pulse WRITE 0x80 -> port[7:0] = 0x80 for 4 cycles, then 0x01; pulse_busy[0] high for those 4 cycles.
REQ-038 Pulse interrupts (macro on): non-pulse WRITE 0x55 at pulse cycle 2 -> 0x55 persists and pulse_busy[0] drops; repeat with rst at cycle 2 -> port = 0.
